// File: rtl/handshaking_slave_pkg.sv
// -----------------------------------------------------------------------------
// hs_pkg : shared types and constants for the handshaking_slave block.
//
// Contents:
//   HS_DATA_W  - default beat width
//   HS_CNT_W   - width of the optional accepted-beat counter
//   hs_state_t - occupancy FSM state (EMPTY / PARTIAL / FULL)
// -----------------------------------------------------------------------------
package hs_pkg;

   localparam int HS_DATA_W = 8;
   localparam int HS_CNT_W  = 16;

   typedef enum logic [1:0] {
      HS_EMPTY   = 2'd0,
      HS_PARTIAL = 2'd1,
      HS_FULL    = 2'd2
   } hs_state_t;

endpackage

// File: rtl/handshaking_slave_if.sv
// -----------------------------------------------------------------------------
// handshaking_slave_if : link and local pop interface of handshaking_slave.
//
// Handshake semantics (link side): a beat transfers on a rising clock edge
// where valid_in=1 and ready_out=1. ready_out depends on registered state only,
// never on valid_in. The master may hold valid_in/data_in for any number of
// cycles; nothing is sampled while ready_out=0.
// Pop side: data_out is the head beat while out_valid=1; rd_en=1 at an edge
// with out_valid=1 removes it. rd_en with out_valid=0 is ignored.
//
// Signals:
//   valid_in, data_in  master -> slave beat offer
//   ready_out          slave  -> master acceptance
//   data_out,out_valid head of the buffer toward local logic
//   rd_en              local logic pop strobe
//   full               buffer holds DEPTH beats
//   state              occupancy FSM state (debug visibility)
//   rx_count           total accepted beats (only with HS_SLAVE_COUNT_EN)
//
// Optional feature macro: HS_SLAVE_COUNT_EN
// -----------------------------------------------------------------------------
interface handshaking_slave_if
   import hs_pkg::*;
#(
   parameter int DATA_W = HS_DATA_W
) ();

   logic              valid_in;
   logic [DATA_W-1:0] data_in;
   logic              ready_out;
   logic [DATA_W-1:0] data_out;
   logic              out_valid;
   logic              rd_en;
   logic              full;
   hs_state_t         state;
`ifdef HS_SLAVE_COUNT_EN
   logic [HS_CNT_W-1:0] rx_count;
`endif

`ifdef HS_SLAVE_COUNT_EN
   modport slave (
      input  valid_in, data_in, rd_en,
      output ready_out, data_out, out_valid, full, state, rx_count
   );
   modport master (
      output valid_in, data_in, rd_en,
      input  ready_out, data_out, out_valid, full, state, rx_count
   );
`else
   modport slave (
      input  valid_in, data_in, rd_en,
      output ready_out, data_out, out_valid, full, state
   );
   modport master (
      output valid_in, data_in, rd_en,
      input  ready_out, data_out, out_valid, full, state
   );
`endif

endinterface

// File: rtl/handshaking_slave_fifo.sv
// -----------------------------------------------------------------------------
// hs_slave_fifo : DEPTH-entry storage with write/read pointers and occupancy.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-low reset (pointers and count only)
//   push     write wr_data at wr_ptr (caller guarantees not full)
//   pop      advance rd_ptr (caller guarantees not empty)
//   wr_data  beat to store
//   rd_data  beat at rd_ptr (stale when empty)
//   count    occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module hs_slave_fifo #(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 4,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic [PTR_W:0]    count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   // Storage is deliberately not reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (rst && push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/handshaking_slave.sv
// -----------------------------------------------------------------------------
// handshaking_slave : receiving end of the valid/ready byte link.
//
// Accepts beats from the master, buffers them in hs_slave_fifo and presents
// them to local logic through a data_out/out_valid/rd_en pop interface.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-low reset
//   bus   handshaking_slave_if.slave (valid_in, data_in, ready_out, data_out,
//         out_valid, rd_en, full, state, rx_count when enabled)
//
// Optional feature macro: HS_SLAVE_COUNT_EN adds the 16-bit rx_count
// accepted-beat counter (wraps silently, cleared by reset).
// -----------------------------------------------------------------------------
module handshaking_slave
   import hs_pkg::*;
#(
   parameter  int DATA_W = HS_DATA_W,
   parameter  int DEPTH  = 4,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input logic                clk,
   input logic                rst,
   handshaking_slave_if.slave bus
);

   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   hs_state_t      state;
   hs_state_t      state_next;
   logic [PTR_W:0] count;
   logic [PTR_W:0] count_next;
   logic           ready;
   logic           out_valid;
   logic           push;
   logic           pop;

   // ready comes from registered occupancy only, so the master's valid_in can
   // never form a combinational loop through this block.
   assign ready = rst & (count != DEPTH_C);
   assign push  = bus.valid_in & ready;
   assign pop   = rst & bus.rd_en & out_valid;

   hs_slave_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data (bus.data_in),
      .rd_data (bus.data_out),
      .count   (count)
   );

   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + 1'b1;
      end else if (pop && !push) begin
         count_next = count - 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= HS_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Next state, decoded from the occupancy after this edge
   always_comb begin
      state_next = state;
      case (state)
         HS_EMPTY: begin
            if (push) state_next = HS_PARTIAL;
         end
         HS_PARTIAL: begin
            if (count_next == '0) begin
               state_next = HS_EMPTY;
            end else if (count_next == DEPTH_C) begin
               state_next = HS_FULL;
            end
         end
         HS_FULL: begin
            if (pop) state_next = HS_PARTIAL;
         end
         default: state_next = HS_EMPTY;
      endcase
   end

   // Outputs; gated by rst so they read 0 for the whole reset window,
   // including before the first reset edge has cleared the state register.
   always_comb begin
      out_valid = rst & (state != HS_EMPTY);
      bus.full  = rst & (state == HS_FULL);
   end

   assign bus.out_valid = out_valid;
   assign bus.ready_out = ready;
   assign bus.state     = state;

`ifdef HS_SLAVE_COUNT_EN
   logic [HS_CNT_W-1:0] rx_count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_count <= '0;
      end else if (push) begin
         rx_count <= rx_count + 1'b1;
      end
   end

   assign bus.rx_count = rx_count;
`endif

endmodule

// File: tb/tb_handshaking_slave.sv
// -----------------------------------------------------------------------------
// tb_handshaking_slave : self-checking bench for handshaking_slave.
// Inputs change 1 time unit after the rising edge; outputs are compared on
// the falling edge. A queue model of the buffer tracks every cycle.
// -----------------------------------------------------------------------------
module tb_handshaking_slave;
   import hs_pkg::*;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   handshaking_slave_if #(.DATA_W(DATA_W)) bus ();

   handshaking_slave #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- scoreboard
   logic [DATA_W-1:0] exp_q[$];
   logic [15:0]       rx_model;
   int                checks = 0;
   int                errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Buffer rules: accept when fewer than DEPTH beats are held (judged before
   // any pop of the same cycle), pop when at least one beat is held.
   task automatic model_check();
      int sz;
      sz = exp_q.size();
      check("ready_out", 32'(bus.ready_out), 32'(rst && (sz < DEPTH)));
      check("out_valid", 32'(bus.out_valid), 32'(rst && (sz > 0)));
      check("full",      32'(bus.full),      32'(rst && (sz == DEPTH)));
      if (rst && sz > 0) begin
         check("data_out", 32'(bus.data_out), 32'(exp_q[0]));
      end
`ifdef HS_SLAVE_COUNT_EN
      check("rx_count", 32'(bus.rx_count), 32'(rx_model));
`endif
   endtask

   task automatic model_update();
      bit do_push;
      bit do_pop;
      if (!rst) begin
         exp_q.delete();
         rx_model = '0;
      end else begin
         do_push = bus.valid_in && (exp_q.size() < DEPTH);
         do_pop  = bus.rd_en && (exp_q.size() > 0);
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) begin
            exp_q.push_back(bus.data_in);
            rx_model = rx_model + 16'd1;
         end
      end
   endtask

   // Called at the falling edge: compare, advance model, move past next edge.
   task automatic tick();
      model_check();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      @(negedge clk);
      tick();
   endtask

   // ---------------------------------------------------------------- driver
   task automatic drive(input logic r, input logic v, input logic [DATA_W-1:0] d,
                        input logic rd);
      rst          = r;
      bus.valid_in = v;
      bus.data_in  = d;
      bus.rd_en    = rd;
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic              r;
      logic              v;
      logic [DATA_W-1:0] d;
      logic              rd;
      logic              e_ready;
      logic              e_ov;
      logic              e_full;
      logic [DATA_W-1:0] e_data;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic v, input logic [DATA_W-1:0] d,
                      input logic rd, input logic er, input logic eov,
                      input logic ef, input logic [DATA_W-1:0] ed);
      vec_t t;
      t = '{r, v, d, rd, er, eov, ef, ed};
      vecs.push_back(t);
   endtask

   // ---------------------------------------------------------------- test
   initial begin
      drive(1'b0, 1'b0, '0, 1'b0);
      rx_model = '0;

      // Reset held 2 cycles with a beat offered, then single beat round trip.
      add(0, 1, 8'h96, 0,   0, 0, 0, 8'h00);
      add(0, 1, 8'h96, 0,   0, 0, 0, 8'h00);
      add(1, 1, 8'h96, 0,   1, 0, 0, 8'h00);
      add(1, 0, 8'h00, 0,   1, 1, 0, 8'h96);
      add(1, 0, 8'h00, 1,   1, 1, 0, 8'h96);
      add(1, 0, 8'h00, 0,   1, 0, 0, 8'h00);
      // Fill to full, offer 0xAA while full.
      add(1, 1, 8'h96, 0,   1, 0, 0, 8'h00);
      add(1, 1, 8'h69, 0,   1, 1, 0, 8'h96);
      add(1, 1, 8'h00, 0,   1, 1, 0, 8'h96);
      add(1, 1, 8'hFF, 0,   1, 1, 0, 8'h96);
      add(1, 1, 8'hAA, 0,   0, 1, 1, 8'h96);
      // Pop with a beat offered while full: pop only; slot reopens next cycle.
      add(1, 1, 8'h55, 1,   0, 1, 1, 8'h96);
      add(1, 1, 8'h55, 0,   1, 1, 0, 8'h69);
      add(1, 0, 8'h00, 1,   0, 1, 1, 8'h69);
      add(1, 0, 8'h00, 1,   1, 1, 0, 8'h00);
      add(1, 0, 8'h00, 1,   1, 1, 0, 8'hFF);
      add(1, 0, 8'h00, 1,   1, 1, 0, 8'h55);
      // rd_en while empty is ignored; push plus rd_en while empty is push only.
      add(1, 0, 8'h00, 1,   1, 0, 0, 8'h00);
      add(1, 1, 8'h77, 1,   1, 0, 0, 8'h00);
      add(1, 0, 8'h00, 0,   1, 1, 0, 8'h77);
      add(1, 0, 8'h00, 1,   1, 1, 0, 8'h77);
      add(1, 0, 8'h00, 0,   1, 0, 0, 8'h00);

      foreach (vecs[i]) begin
         drive(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].rd);
         @(negedge clk);
         check($sformatf("vec%0d_ready", i), 32'(bus.ready_out), 32'(vecs[i].e_ready));
         check($sformatf("vec%0d_ovalid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
         check($sformatf("vec%0d_full", i), 32'(bus.full), 32'(vecs[i].e_full));
         if (vecs[i].e_ov) begin
            check($sformatf("vec%0d_data", i), 32'(bus.data_out), 32'(vecs[i].e_data));
         end
         tick();
      end

      // Streaming: push and pop every cycle, one beat in flight, no stall.
      drive(1'b0, 1'b0, '0, 1'b0);
      step();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, 8'(i), 1'b1);
         @(negedge clk);
         check("stream_ready", 32'(bus.ready_out), 32'd1);
         check("stream_full", 32'(bus.full), 32'd0);
         check("stream_ovalid", 32'(bus.out_valid), 32'(i > 0));
         if (i > 0) check("stream_data", 32'(bus.data_out), 32'(i - 1));
         tick();
      end
      drive(1'b1, 1'b0, '0, 1'b1);
      @(negedge clk);
      check("stream_last", 32'(bus.data_out), 32'h13);
`ifdef HS_SLAVE_COUNT_EN
      check("stream_rx_count", 32'(bus.rx_count), 32'd20);
`endif
      tick();
      drive(1'b1, 1'b0, '0, 1'b0);
      @(negedge clk);
      check("stream_drained", 32'(bus.out_valid), 32'd0);
      tick();

      // Mid-operation reset discards three buffered beats.
      drive(1'b1, 1'b1, 8'h11, 1'b0); step();
      drive(1'b1, 1'b1, 8'h22, 1'b0); step();
      drive(1'b1, 1'b1, 8'h33, 1'b0); step();
      drive(1'b0, 1'b1, 8'h44, 1'b0);
      @(negedge clk);
      check("midrst_ready", 32'(bus.ready_out), 32'd0);
      check("midrst_ovalid", 32'(bus.out_valid), 32'd0);
      tick();
      drive(1'b1, 1'b1, 8'h3C, 1'b0);
      @(negedge clk);
      check("postrst_ovalid", 32'(bus.out_valid), 32'd0);
      check("postrst_full", 32'(bus.full), 32'd0);
`ifdef HS_SLAVE_COUNT_EN
      check("postrst_rx_count", 32'(bus.rx_count), 32'd0);
`endif
      tick();
      drive(1'b1, 1'b0, '0, 1'b1);
      @(negedge clk);
      check("postrst_data", 32'(bus.data_out), 32'h3C);
      tick();
      drive(1'b1, 1'b0, '0, 1'b0);
      @(negedge clk);
      check("postrst_sole", 32'(bus.out_valid), 32'd0);
      tick();

      // Randomized traffic in three phases: fill-biased, balanced, drain-biased.
      for (int ph = 0; ph < 3; ph++) begin
         for (int n = 0; n < 200; n++) begin
            logic r, v, rd;
            r  = ($urandom_range(0, 59) != 0);
            v  = ($urandom_range(0, 3) < (3 - ph));
            rd = ($urandom_range(0, 3) < (ph + 1));
            drive(r, v, 8'($urandom), rd);
            step();
         end
      end

      drive(1'b1, 1'b0, '0, 1'b0);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/handshaking_slave.md
Name: handshaking_slave

Overview:
- Receiving end of the valid/ready byte handshake driven by handshaking_master.
- Accepts beats on valid_in/data_in, backpressures through ready_out, and buffers beats in a DEPTH-entry FIFO.
- Presents buffered beats to local logic through a data_out/out_valid/rd_en pop interface.
- Sits opposite handshaking_master on the same link, in the same clock domain.

Parameters:
- DATA_W, 8, width of data_in/data_out.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous and active-low (0 = reset, sampled on rising edge of clk).
- valid_in  input  1  master asserts: data_in holds a beat.
- data_in  input  DATA_W  beat from master.
- ready_out  output  1  slave can accept a beat this cycle.
- data_out  output  DATA_W  head-of-FIFO beat.
- out_valid  output  1  data_out is valid (FIFO non-empty).
- rd_en  input  1  local consumer pops head when out_valid=1.
- full  output  1  count==DEPTH.
- rx_count  output  16  (only with HS_SLAVE_COUNT_EN) total accepted beats.

Behaviour:
- Transfer (push) occurs at a rising edge where rst=1, valid_in=1 and ready_out=1; data_in is written at wr_ptr, wr_ptr++, count++.
- ready_out = rst & (count != DEPTH).
  - Combinational from registers only; never depends on valid_in (no comb loop with master).
- Pop occurs at an edge where rd_en=1 and out_valid=1; rd_ptr++, count--.
- rd_en while out_valid=0 is ignored.
- out_valid = (count != 0); data_out = mem[rd_ptr]. Shows stale memory when empty; bench must not check it then.
- Latency: beat accepted at edge N is on data_out with out_valid=1 after edge N (cycle N+1) when the FIFO was empty.
- Simultaneous push and pop with 0<count<DEPTH: both happen, count unchanged.
- Full:
  - ready_out=0, so a push is impossible.
  - A pop while full frees a slot; ready_out returns to 1 the next cycle, not in the same cycle.
- Empty: a push plus rd_en in the same cycle gives push only; rd_en is ignored.
- Pointers wrap modulo DEPTH. count is PTR_W+1 bits, range 0..DEPTH.
- FSM state register, decoded from next count:
  - EMPTY (count 0): push to PARTIAL; DEPTH==1 is not allowed.
  - PARTIAL: push-only reaching DEPTH goes to FULL; pop-only reaching 0 goes to EMPTY; otherwise stays.
  - FULL: pop goes to PARTIAL.
  - full = (state==FULL); out_valid = (state!=EMPTY).
- Reset (rst=0 at an edge): state=EMPTY, count=0, wr_ptr=rd_ptr=0, rx_count=0.
  - While rst=0: ready_out=0, out_valid=0, full=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all buffered beats; any beat offered during reset is not accepted.
- data_in is sampled only on an accepted beat. Master holding valid_in with ready_out=0 has no effect.

Optional Feature:
- Macro HS_SLAVE_COUNT_EN.
- Defined:
  - rx_count port exists, a 16-bit counter incremented on each accepted beat.
  - Wraps 0xFFFF to 0x0000 silently; cleared by reset.
- Undefined:
  - Port and counter are absent; all other behaviour is identical.

Decomposition:
- Package hs_pkg:
  - HS_DATA_W=8 default.
  - State typedef/localparams HS_EMPTY=2'd0, HS_PARTIAL=2'd1, HS_FULL=2'd2.
  - HS_CNT_W=16.
- One sub-module, hs_slave_fifo: storage array plus pointers/count with push/pop strobes.
- handshaking_slave holds the FSM, handshake qualification and the optional counter.

Test Plan:
- Reset: hold rst=0 for 2 cycles with valid_in=1, data_in=0x96 -> ready_out=0, out_valid=0 throughout; after release, count=0 and ready_out=1 on first cycle.
- Single beat: valid_in=1, data_in=0x96 for one cycle -> next cycle out_valid=1, data_out=0x96; rd_en=1 one cycle -> out_valid=0.
- Fill to full: push 0x96,0x69,0x00,0xFF back-to-back, rd_en=0 -> full=1, ready_out=0.
  - Then offer 0xAA: not accepted.
  - Pops return 0x96,0x69,0x00,0xFF in order.
- Full + pop: at full, assert rd_en and valid_in(0x55) same cycle -> pop only; ready_out=1 next cycle, then 0x55 accepted; final pop order ends with 0x55.
- Streaming: valid_in=1 and rd_en=1 every cycle for 20 beats of incrementing data 0x00..0x13 -> count stays 1, no stall, output order matches.
  - With HS_SLAVE_COUNT_EN: rx_count=20.
- Mid-operation reset: 3 beats buffered, rst=0 one cycle -> out_valid=0, full=0, rx_count=0; next push 0x3C appears as sole entry.
